// File: rtl/elevator_pkg.sv
// Shared constants and the direction-state type for the floor request front end.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS      = 10;
    localparam int DEF_FLOOR_W         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_state_t;

    // Counter width for a debounce period; never narrower than one bit.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One switch: 2-FF synchroniser, then a stability counter that accepts a new level
// after DEBOUNCE_CYCLES consecutive disagreeing samples. Emits a pulse on accepted presses.
module button_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, debounce counter, stable level and press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= '0;
            stable  <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r == stable) begin
                cnt_r <= '0;
                press <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r  <= '0;
                stable <= sync2_r;
                press  <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                press <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/floor_request_latch.sv
// Debounced floor buttons feeding a per-floor request latch and a SCAN direction FSM.
// Build option REQ_CANCEL_EN: a press on an already-pending floor cancels it.
module floor_request_latch
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_raw,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  serve,
    output logic [NUM_FLOORS-1:0] req_pending,
    output logic [FLOOR_W-1:0]    next_floor,
    output logic                  next_valid,
    output logic                  dir_up
);

    logic [NUM_FLOORS-1:0] press_s;
    logic [NUM_FLOORS-1:0] unused_stable_s;
    logic [NUM_FLOORS-1:0] clear_s;
    logic [NUM_FLOORS-1:0] req_next_s;
    logic                  above_s;
    logic                  below_s;
    logic                  at_cur_s;
    logic [FLOOR_W-1:0]    lowest_above_s;
    logic [FLOOR_W-1:0]    highest_below_s;
    logic [FLOOR_W-1:0]    fallback_s;
    dir_state_t            state_r;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[g]),
            .stable (unused_stable_s[g]),
            .press  (press_s[g])
        );
    end

    // Serve decode; an out-of-range cur_floor matches no bit and is ignored.
    always_comb begin
        clear_s = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clear_s[i] = serve && (cur_floor == FLOOR_W'(i));
        end
    end

    // Next request vector: clear always beats a coincident press.
    always_comb begin
`ifdef REQ_CANCEL_EN
        req_next_s = (req_pending ^ press_s) & ~clear_s;
`else
        req_next_s = (req_pending | press_s) & ~clear_s;
`endif
    end

    // Request latch register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pending <= '0;
        end else begin
            req_pending <= req_next_s;
        end
    end

    // Priority encoders relative to cur_floor; scan direction picks the winner.
    always_comb begin
        above_s         = 1'b0;
        below_s         = 1'b0;
        at_cur_s        = 1'b0;
        lowest_above_s  = '0;
        highest_below_s = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            above_s        = above_s | (req_pending[i] && (FLOOR_W'(i) > cur_floor));
            lowest_above_s = (req_pending[i] && (FLOOR_W'(i) > cur_floor)) ?
                             FLOOR_W'(i) : lowest_above_s;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            below_s         = below_s | (req_pending[i] && (FLOOR_W'(i) < cur_floor));
            highest_below_s = (req_pending[i] && (FLOOR_W'(i) < cur_floor)) ?
                              FLOOR_W'(i) : highest_below_s;
            at_cur_s        = at_cur_s | (req_pending[i] && (FLOOR_W'(i) == cur_floor));
        end
        fallback_s = at_cur_s ? cur_floor : '0;
    end

    // SCAN FSM; outputs follow the state one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            next_floor <= '0;
            next_valid <= 1'b0;
            dir_up     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (above_s)      state_r <= UP;
                    else if (below_s) state_r <= DOWN;
                    else              state_r <= IDLE;
                end
                UP: begin
                    if (above_s)      state_r <= UP;
                    else if (below_s) state_r <= DOWN;
                    else              state_r <= IDLE;
                end
                DOWN: begin
                    if (below_s)      state_r <= DOWN;
                    else if (above_s) state_r <= UP;
                    else              state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase

            case (state_r)
                UP:      next_floor <= above_s ? lowest_above_s : fallback_s;
                DOWN:    next_floor <= below_s ? highest_below_s : fallback_s;
                default: next_floor <= fallback_s;
            endcase
            next_valid <= |req_pending;
            dir_up     <= (state_r == UP);
        end
    end

endmodule

// File: tb/tb_floor_request_latch.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_floor_request_latch;

    localparam int NF = 10;
    localparam int FW = 4;
    localparam int DB = 4;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] btn_raw;
    logic [FW-1:0] cur_floor;
    logic          serve;
    logic [NF-1:0] req_pending;
    logic [FW-1:0] next_floor;
    logic          next_valid;
    logic          dir_up;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [NF-1:0] m_s1, m_s2, m_stable, m_press, m_req;
    int            m_run [NF];
    int            m_dir;
    int            m_cur_prev;
    int            settle;

    floor_request_latch #(
        .NUM_FLOORS     (NF),
        .FLOOR_W        (FW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .cur_floor  (cur_floor),
        .serve      (serve),
        .req_pending(req_pending),
        .next_floor (next_floor),
        .next_valid (next_valid),
        .dir_up     (dir_up)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_req = '0;
        for (int i = 0; i < NF; i++) m_run[i] = 0;
        m_dir = M_IDLE;
        m_cur_prev = -1;
        settle = 0;
    endtask

    task automatic model_step();
        logic [NF-1:0] nreq;
        int above, below, ndir, cur;
        if (!reset) begin
            model_reset();
            return;
        end
        cur = int'(cur_floor);
        nreq = m_req;
        for (int i = 0; i < NF; i++) begin
            if (m_press[i]) begin
`ifdef REQ_CANCEL_EN
                nreq[i] = ~m_req[i];
`else
                nreq[i] = 1'b1;
`endif
            end
        end
        if (serve && cur < NF) nreq[cur] = 1'b0;
        above = 0; below = 0;
        for (int i = 0; i < NF; i++) begin
            if (m_req[i] && i > cur) above = 1;
            if (m_req[i] && i < cur) below = 1;
        end
        if (m_dir == M_DOWN) ndir = below ? M_DOWN : (above ? M_UP : M_IDLE);
        else if (m_dir == M_UP) ndir = above ? M_UP : (below ? M_DOWN : M_IDLE);
        else ndir = above ? M_UP : (below ? M_DOWN : M_IDLE);
        // a level is accepted once DB consecutive synchronised samples disagree with it
        for (int i = 0; i < NF; i++) begin
            m_press[i] = 1'b0;
            if (m_s2[i] == m_stable[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stable[i] = m_s2[i];
                    m_run[i] = 0;
                    m_press[i] = m_s2[i];
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
        if (nreq == m_req && ndir == m_dir && cur == m_cur_prev) settle++;
        else settle = 0;
        m_cur_prev = cur;
        m_req = nreq;
        m_dir = ndir;
    endtask

    function automatic int exp_next();
        int cur = int'(cur_floor);
        int r = 0;
        if (m_dir == M_UP) begin
            for (int i = NF - 1; i > cur; i--) if (m_req[i]) r = i;
        end else if (m_dir == M_DOWN) begin
            for (int i = 0; i < NF && i < cur; i++) if (m_req[i]) r = i;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("req_pending", 32'(req_pending), 32'(m_req));
        if (reset && settle >= 2) begin
            check_val("next_valid", 32'(next_valid), 32'(|m_req));
            check_val("dir_up", 32'(dir_up), 32'(m_dir == M_UP));
            if (|m_req) check_val("next_floor", 32'(next_floor), 32'(exp_next()));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_val("rst_req", 32'(req_pending), 32'd0);
        check_val("rst_next_floor", 32'(next_floor), 32'd0);
        check_val("rst_valid", 32'(next_valid), 32'd0);
        check_val("rst_dir_up", 32'(dir_up), 32'd0);
        ticks(2);
        reset = 1'b1;
        ticks(1);
    endtask

    initial begin
        btn_raw = '0; cur_floor = '0; serve = 1'b0; reset = 1'b1;
        model_reset();
        #2;
        do_reset();

        // 1: clean press, exact latency, then direction up to floor 3
        cur_floor = 4'd0;
        btn_raw[3] = 1'b1;
        ticks(6);
        check_val("t1_not_yet", 32'(req_pending[3]), 32'd0);
        ticks(1);
        check_val("t1_latency", 32'(req_pending[3]), 32'd1);
        ticks(3);
        btn_raw[3] = 1'b0;
        ticks(8);
        check_val("t1_dir_up", 32'(dir_up), 32'd1);
        check_val("t1_next_floor", 32'(next_floor), 32'd3);
        check_val("t1_next_valid", 32'(next_valid), 32'd1);

        // 2: short glitch is rejected
        do_reset();
        btn_raw[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t2_press", 32'(dut.press_s), 32'd0);
        end
        btn_raw[5] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("t2_press", 32'(dut.press_s), 32'd0);
        end
        check_val("t2_req", 32'(req_pending), 32'd0);

        // 3: pending {2,7}, serve at 7 turns the scan downward
        do_reset();
        cur_floor = 4'd4;
        btn_raw[2] = 1'b1; btn_raw[7] = 1'b1;
        ticks(8);
        btn_raw = '0;
        ticks(6);
        check_val("t3_up", 32'(dir_up), 32'd1);
        check_val("t3_up_target", 32'(next_floor), 32'd7);
        cur_floor = 4'd7;
        ticks(2);
        serve = 1'b1;
        ticks(1);
        serve = 1'b0;
        check_val("t3_clear", 32'(req_pending), 32'h004);
        ticks(4);
        check_val("t3_dir_down", 32'(dir_up), 32'd0);
        check_val("t3_target", 32'(next_floor), 32'd2);
        check_val("t3_valid", 32'(next_valid), 32'd1);

        // 4: press and serve on floor 6 land on the same edge
        do_reset();
        cur_floor = 4'd6;
        btn_raw[6] = 1'b1;
        ticks(6);
        serve = 1'b1;
        ticks(1);
        serve = 1'b0;
        check_val("t4_clear_wins", 32'(req_pending[6]), 32'd0);
        ticks(3);
        btn_raw[6] = 1'b0;
        ticks(8);
        check_val("t4_stays_clear", 32'(req_pending), 32'd0);

        // 5: repeat press on pending floor 1; out-of-range serve ignored
        do_reset();
        cur_floor = 4'd5;
        btn_raw[1] = 1'b1; ticks(8); btn_raw[1] = 1'b0; ticks(8);
        check_val("t5_first", 32'(req_pending[1]), 32'd1);
        cur_floor = 4'd12;
        serve = 1'b1; ticks(1); serve = 1'b0;
        check_val("t5_oor_serve", 32'(req_pending[1]), 32'd1);
        cur_floor = 4'd5;
        btn_raw[1] = 1'b1; ticks(8); btn_raw[1] = 1'b0; ticks(8);
`ifdef REQ_CANCEL_EN
        check_val("t5_repeat", 32'(req_pending[1]), 32'd0);
`else
        check_val("t5_repeat", 32'(req_pending[1]), 32'd1);
`endif

        // 6: async reset with requests pending and a press mid-debounce
        do_reset();
        cur_floor = 4'd4;
        btn_raw[0] = 1'b1; btn_raw[8] = 1'b1; ticks(8); btn_raw = '0; ticks(6);
        check_val("t6_pending", 32'(req_pending), 32'h101);
        btn_raw[9] = 1'b1;
        ticks(3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_val("t6_req_async", 32'(req_pending), 32'd0);
        check_val("t6_floor_async", 32'(next_floor), 32'd0);
        check_val("t6_valid_async", 32'(next_valid), 32'd0);
        check_val("t6_dir_async", 32'(dir_up), 32'd0);
        btn_raw = '0;
        ticks(2);
        reset = 1'b1;
        ticks(12);
        check_val("t6_no_stale", 32'(req_pending), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
            end
            if ($urandom_range(0, 11) == 0) cur_floor = 4'($urandom_range(0, 11));
            serve = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_val("rnd_async_rst", 32'(req_pending), 32'd0);
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
